fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Dual-issue fetch front end: requests (pc, pc+4) each cycle and queues returned pairs for decode.
// Latency: issue at t, memory data at t+1, pair visible to decode at t+2; redirect target visible at t+3.
// Backpressure: issue stops once queued plus in-flight pairs would exceed QueueDepth; head holds while not ready.
module fetch_unit #(
    parameter logic [31:0] ResetPc    = 32'h0000_0000,
    parameter int          QueueDepth = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr_a,
    output logic [31:0] imem_addr_b,
    input  logic [31:0] imem_data_a,
    input  logic [31:0] imem_data_b,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_instr_a,
    output logic [31:0] fetch_instr_b
);

    localparam int PW = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
    localparam int CW = PW + 1;
    localparam int OW = CW + 1;

    logic [31:0]   pc_q;
    logic [31:0]   inflight_pc_q;
    logic          inflight_q;
    logic [31:0]   q_pc    [QueueDepth];
    logic [31:0]   q_instr_a [QueueDepth];
    logic [31:0]   q_instr_b [QueueDepth];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          pop;
    logic          push;
    logic          issue;
    logic [OW-1:0] occupancy;
    logic          redirect_lsb_unused;

    // The low two bits of the redirect target are forced to zero, so they are not consumed.
    assign redirect_lsb_unused = ^redirect_pc[1:0];

    assign fetch_valid = (count != '0);
    assign pop         = fetch_valid & fetch_ready;
    assign push        = inflight_q & ~redirect_valid;

    // Slots that will be committed after this cycle: queued pairs plus the outstanding response.
    assign occupancy   = OW'(count) + OW'(inflight_q) - OW'(pop);
    assign issue       = ~redirect_valid && (occupancy < OW'(QueueDepth));

    assign imem_addr_a = pc_q;
    assign imem_addr_b = pc_q + 32'd4;

    assign fetch_pc      = fetch_valid ? q_pc[rd_ptr]      : 32'h0;
    assign fetch_instr_a = fetch_valid ? q_instr_a[rd_ptr] : 32'h0;
    assign fetch_instr_b = fetch_valid ? q_instr_b[rd_ptr] : 32'h0;

    // PC sequencing and the single outstanding-request tracker; redirect overrides issue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= ResetPc;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
        end else if (redirect_valid) begin
            pc_q       <= {redirect_pc[31:2], 2'b00};
            inflight_q <= 1'b0;
        end else if (issue) begin
            pc_q          <= pc_q + 32'd8;
            inflight_q    <= 1'b1;
            inflight_pc_q <= pc_q;
        end else begin
            inflight_q <= 1'b0;
        end
    end

    // Queue pointers and occupancy; a redirect flushes everything, including a same-cycle pop.
    always_ff @(posedge clk) begin
        if (!rst_n || redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue payload storage; contents are meaningless while count is zero, so no reset.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            q_pc[wr_ptr]      <= inflight_pc_q;
            q_instr_a[wr_ptr] <= imem_data_a;
            q_instr_b[wr_ptr] <= imem_data_b;
        end
    end

    // Issue throttling should make a push into a full queue unreachable.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && !pop && (count == CW'(QueueDepth))));
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_ready;

    logic [31:0] addr_a, addr_b, data_a, data_b;
    logic        fvalid;
    logic [31:0] fpc, fia, fib;

    logic [31:0] addr_a2, addr_b2, data_a2, data_b2;
    logic        fvalid2;
    logic [31:0] fpc2, fia2, fib2;
    logic        no_redirect = 1'b0;
    logic [31:0] zero_pc = 32'h0;

    always #5 clk = ~clk;

    fetch_unit #(.ResetPc(32'h0000_0000), .QueueDepth(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr_a(addr_a), .imem_addr_b(addr_b),
        .imem_data_a(data_a), .imem_data_b(data_b),
        .fetch_valid(fvalid), .fetch_ready(fetch_ready),
        .fetch_pc(fpc), .fetch_instr_a(fia), .fetch_instr_b(fib)
    );

    fetch_unit #(.ResetPc(32'hFFFF_FFFC), .QueueDepth(2)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(no_redirect), .redirect_pc(zero_pc),
        .imem_addr_a(addr_a2), .imem_addr_b(addr_b2),
        .imem_data_a(data_a2), .imem_data_b(data_b2),
        .fetch_valid(fvalid2), .fetch_ready(fetch_ready),
        .fetch_pc(fpc2), .fetch_instr_a(fia2), .fetch_instr_b(fib2)
    );

    // Memory image: word i holds 0x1000 + i.
    function automatic logic [31:0] word(input logic [31:0] addr);
        return 32'h1000 + (addr >> 2);
    endfunction

    always @(posedge clk) begin
        data_a  <= word(addr_a);
        data_b  <= word(addr_b);
        data_a2 <= word(addr_a2);
        data_b2 <= word(addr_b2);
    end

    typedef struct {
        logic        rst_n;
        logic        redir;
        logic [31:0] redir_pc;
        logic        ready;
        logic        chk;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
    } pair_t;

    localparam int NV = 28;
    vec_t  vecs [NV];
    pair_t sb [$];

    int n_chk  = 0;
    int n_fail = 0;
    int n_hs   = 0;

    logic        hold_prev = 1'b0;
    logic [31:0] hold_pc, hold_a, hold_b;

    function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] rpc,
                                input logic rdy, input logic c, input logic ev,
                                input logic [31:0] epc, input logic [31:0] ea);
        vec_t v;
        v.rst_n = r; v.redir = rd; v.redir_pc = rpc; v.ready = rdy;
        v.chk = c; v.exp_valid = ev; v.exp_pc = epc; v.exp_addr = ea;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic refill(input logic [31:0] start);
        logic [31:0] p;
        sb.delete();
        p = {start[31:2], 2'b00};
        for (int k = 0; k < 16; k++) begin
            sb.push_back('{pc: p, a: word(p), b: word(p + 32'd4)});
            p = p + 32'd8;
        end
    endtask

    // Called mid-cycle, after row inputs are applied and before the consuming edge.
    task automatic check_row(input int i);
        pair_t e;
        if (vecs[i].chk) begin
            check32($sformatf("row%0d valid", i), {31'b0, fvalid}, {31'b0, vecs[i].exp_valid});
            check32($sformatf("row%0d pc", i), fpc, vecs[i].exp_pc);
            check32($sformatf("row%0d addr_a", i), addr_a, vecs[i].exp_addr);
            check32($sformatf("row%0d addr_b", i), addr_b, vecs[i].exp_addr + 32'd4);
            if (!vecs[i].exp_valid)
                check32($sformatf("row%0d idle data", i), fia | fib, 32'h0);
        end
        if (hold_prev) begin
            check32($sformatf("row%0d hold valid", i), {31'b0, fvalid}, 32'h1);
            check32($sformatf("row%0d hold pc", i), fpc, hold_pc);
            check32($sformatf("row%0d hold a", i), fia, hold_a);
            check32($sformatf("row%0d hold b", i), fib, hold_b);
        end
        if (fvalid === 1'b1 && fetch_ready === 1'b1) begin
            n_hs++;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL row%0d sb: got pc %h, expected no pair", i, fpc);
            end else begin
                e = sb.pop_front();
                check32($sformatf("row%0d sb pc", i), fpc, e.pc);
                check32($sformatf("row%0d sb a", i), fia, e.a);
                check32($sformatf("row%0d sb b", i), fib, e.b);
            end
        end
        hold_prev = (fvalid === 1'b1) && !fetch_ready && rst_n && !redirect_valid;
        hold_pc = fpc; hold_a = fia; hold_b = fib;
        if (!rst_n) refill(32'h0);
        else if (redirect_valid) refill(redirect_pc);
    endtask

    // Wrap-around instance starting at 0xFFFF_FFFC with redirect tied off.
    task automatic check_wrap(input int i);
        case (i)
            1: begin
                check32("wrap reset addr_a", addr_a2, 32'hFFFF_FFFC);
                check32("wrap reset addr_b", addr_b2, 32'h0000_0000);
                check32("wrap reset valid", {31'b0, fvalid2}, 32'h0);
            end
            3: check32("wrap next pair addr", addr_a2, 32'h0000_0004);
            4: begin
                check32("wrap head pc", fpc2, 32'hFFFF_FFFC);
                check32("wrap head a", fia2, 32'h4000_0FFF);
                check32("wrap head b", fib2, 32'h0000_1000);
            end
            5: begin
                check32("wrap second pc", fpc2, 32'h0000_0004);
                check32("wrap second a", fia2, 32'h0000_1001);
                check32("wrap second b", fib2, 32'h0000_1002);
            end
            default: ;
        endcase
    endtask

    initial begin
        //               rst redir rpc            rdy chk ev  exp_pc         exp_addr
        vecs[0]  = mk(0, 0, 32'h0,          1, 0, 0, 32'h0,          32'h0);
        vecs[1]  = mk(0, 0, 32'h0,          1, 1, 0, 32'h0,          32'h0);
        vecs[2]  = mk(1, 0, 32'h0,          1, 1, 0, 32'h0,          32'h0);
        vecs[3]  = mk(1, 0, 32'h0,          1, 1, 0, 32'h0,          32'h8);
        vecs[4]  = mk(1, 0, 32'h0,          1, 1, 1, 32'h0,          32'h10);
        vecs[5]  = mk(1, 0, 32'h0,          0, 1, 1, 32'h8,          32'h18);
        vecs[6]  = mk(1, 0, 32'h0,          0, 1, 1, 32'h8,          32'h18);
        vecs[7]  = mk(1, 0, 32'h0,          0, 1, 1, 32'h8,          32'h18);
        vecs[8]  = mk(1, 0, 32'h0,          0, 1, 1, 32'h8,          32'h18);
        vecs[9]  = mk(1, 0, 32'h0,          0, 1, 1, 32'h8,          32'h18);
        vecs[10] = mk(1, 0, 32'h0,          0, 1, 1, 32'h8,          32'h18);
        vecs[11] = mk(1, 0, 32'h0,          1, 1, 1, 32'h8,          32'h18);
        vecs[12] = mk(1, 0, 32'h0,          1, 1, 1, 32'h10,         32'h20);
        vecs[13] = mk(1, 0, 32'h0,          1, 1, 1, 32'h18,         32'h28);
        vecs[14] = mk(1, 1, 32'h0000_0102,  0, 1, 1, 32'h20,         32'h30);
        vecs[15] = mk(1, 0, 32'h0,          1, 1, 0, 32'h0,          32'h100);
        vecs[16] = mk(1, 0, 32'h0,          1, 1, 0, 32'h0,          32'h108);
        vecs[17] = mk(1, 0, 32'h0,          1, 1, 1, 32'h100,        32'h110);
        vecs[18] = mk(1, 1, 32'hFFFF_FFF8,  1, 1, 1, 32'h108,        32'h118);
        vecs[19] = mk(1, 0, 32'h0,          1, 1, 0, 32'h0,          32'hFFFF_FFF8);
        vecs[20] = mk(1, 0, 32'h0,          1, 1, 0, 32'h0,          32'h0);
        vecs[21] = mk(1, 0, 32'h0,          1, 1, 1, 32'hFFFF_FFF8,  32'h8);
        vecs[22] = mk(1, 0, 32'h0,          1, 1, 1, 32'h0,          32'h10);
        vecs[23] = mk(0, 0, 32'h0,          1, 1, 1, 32'h8,          32'h18);
        vecs[24] = mk(1, 0, 32'h0,          1, 1, 0, 32'h0,          32'h0);
        vecs[25] = mk(1, 0, 32'h0,          1, 1, 0, 32'h0,          32'h8);
        vecs[26] = mk(1, 0, 32'h0,          1, 1, 1, 32'h0,          32'h10);
        vecs[27] = mk(1, 0, 32'h0,          1, 1, 1, 32'h8,          32'h18);

        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; fetch_ready = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < NV; i++) begin
            rst_n          = vecs[i].rst_n;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].redir_pc;
            fetch_ready    = vecs[i].ready;
            @(negedge clk);
            check_row(i);
            check_wrap(i);
            @(posedge clk);
            #1;
        end
        check32("handshake total", n_hs, 32'd11);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
